// File: rtl/stream_mux_rr.sv
// N-channel registered valid/ready stream mux with fixed-select or round-robin arbitration.
// Define STREAM_MUX_PARITY_EN to add the registered even-parity output Y_par.
`timescale 1ns/1ps
module stream_mux_rr #(
  parameter int N_CH  = 8,
  parameter int W     = 8,
  parameter int SEL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] D,
  input  logic [N_CH-1:0]   D_valid,
  output logic [N_CH-1:0]   D_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  S,
  output logic [W-1:0]      Y,
  output logic              Y_valid,
  input  logic              Y_ready,
  output logic [SEL_W-1:0]  Y_ch
`ifdef STREAM_MUX_PARITY_EN
  ,
  output logic              Y_par
`endif
);

  logic [W-1:0]     y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [SEL_W-1:0] y_ch_q, y_ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] cand;
  logic [W-1:0]     grant_data;
  logic             accept;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    load_en    = !y_valid_q || Y_ready;
    grant_vld  = 1'b0;
    grant      = '0;
    cand       = '0;
    grant_data = '0;

    if (!mode) begin
      if (int'(S) < N_CH && D_valid[S]) begin
        grant_vld = 1'b1;
        grant     = S;
      end
    end else begin
      // Search starts one past the last winner, so the previous winner has lowest priority.
      for (int i = 1; i <= N_CH; i++) begin
        cand = SEL_W'((int'(ptr_q) + i) % N_CH);
        if (!grant_vld && D_valid[cand]) begin
          grant_vld = 1'b1;
          grant     = cand;
        end
      end
    end

    accept = grant_vld && load_en && !rst;

    D_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        D_ready[i] = accept;
        grant_data = D[i*W +: W];
      end
    end

    y_d       = accept ? grant_data : y_q;
    y_ch_d    = accept ? grant : y_ch_q;
    ptr_d     = accept ? grant : ptr_q;
    y_valid_d = accept || (y_valid_q && !Y_ready);
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_ch_q    <= '0;
      ptr_q     <= SEL_W'(N_CH - 1);
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_ch_q    <= y_ch_d;
      ptr_q     <= ptr_d;
    end
  end

  assign Y       = y_q;
  assign Y_valid = y_valid_q;
  assign Y_ch    = y_ch_q;

`ifdef STREAM_MUX_PARITY_EN
  logic y_par_q, y_par_d;

  always_comb y_par_d = accept ? ^grant_data : y_par_q;

  always_ff @(posedge clk) begin
    if (rst) y_par_q <= 1'b0;
    else     y_par_q <= y_par_d;
  end

  assign Y_par = y_par_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed-vector bench for stream_mux_rr (N_CH=8, W=8) with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_stream_mux_rr;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] ch;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] D;
  logic [7:0]  D_valid;
  logic [7:0]  D_ready;
  logic        mode;
  logic [2:0]  S;
  logic [7:0]  Y;
  logic        Y_valid;
  logic        Y_ready;
  logic [2:0]  Y_ch;
`ifdef STREAM_MUX_PARITY_EN
  logic        Y_par;
`endif

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  stream_mux_rr #(.N_CH(8), .W(8), .SEL_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .D       (D),
    .D_valid (D_valid),
    .D_ready (D_ready),
    .mode    (mode),
    .S       (S),
    .Y       (Y),
    .Y_valid (Y_valid),
    .Y_ready (Y_ready),
    .Y_ch    (Y_ch)
`ifdef STREAM_MUX_PARITY_EN
    ,
    .Y_par   (Y_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] val);
    D[ch*8 +: 8] = val;
  endtask

  task automatic expect_beat(input logic [7:0] data, input logic [2:0] ch);
    beat_t b;
    b.data = data;
    b.ch   = ch;
    exp_q.push_back(b);
  endtask

  // Monitor: every output handshake pops one expected beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && Y_valid && Y_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h ch %0d, none expected", Y, Y_ch);
        end else begin
          e = exp_q.pop_front();
          check("y_data", Y, e.data);
          check("y_ch", Y_ch, e.ch);
`ifdef STREAM_MUX_PARITY_EN
          check("y_par", Y_par, ^e.data);
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    mode    = 1'b0;
    S       = 3'd0;
    Y_ready = 1'b1;
    D_valid = 8'hFF;
    for (int i = 0; i < 8; i++) set_ch(i, 8'hA0 + 8'(i));

    // Reset held two cycles with all channels valid.
    repeat (2) begin
      @(negedge clk);
      check("rst_y_valid", Y_valid, 0);
      check("rst_y", Y, 0);
      check("rst_y_ch", Y_ch, 0);
      check("rst_d_ready", D_ready, 0);
      step();
    end
    rst = 1'b0;

    // Fixed select of channel 5.
    S = 3'd5;
    @(negedge clk);
    check("fixed_d_ready", D_ready, 8'h20);
    expect_beat(8'hA5, 3'd5);
    step();
    S       = 3'd7;
    D_valid = 8'h7F;
    @(negedge clk);
    check("fixed_no_grant_d_ready", D_ready, 0);
    step();
    @(negedge clk);
    check("fixed_drained_y_valid", Y_valid, 0);

    // Round-robin from reset: all channels valid.
    rst = 1'b1;
    step();
    rst     = 1'b0;
    mode    = 1'b1;
    D_valid = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      expect_beat(8'hA0 + 8'(k % 8), 3'(k % 8));
      step();
    end
    D_valid = 8'b0100_0100;
    expect_beat(8'hA2, 3'd2);
    expect_beat(8'hA6, 3'd6);
    expect_beat(8'hA2, 3'd2);
    expect_beat(8'hA6, 3'd6);
    repeat (4) step();
    D_valid = 8'h00;
    step();
    @(negedge clk);
    check("rr_drained_y_valid", Y_valid, 0);

    // Backpressure: hold 3C from channel 2, then replace with 5A from channel 3.
    mode = 1'b0;
    S    = 3'd2;
    set_ch(2, 8'h3C);
    set_ch(3, 8'h5A);
    D_valid = 8'h04;
    expect_beat(8'h3C, 3'd2);
    step();
    Y_ready = 1'b0;
    S       = 3'd3;
    D_valid = 8'h08;
    repeat (4) begin
      @(negedge clk);
      check("stall_y", Y, 8'h3C);
      check("stall_y_ch", Y_ch, 2);
      check("stall_y_valid", Y_valid, 1);
      check("stall_d_ready", D_ready, 0);
      step();
    end
    Y_ready = 1'b1;
    @(negedge clk);
    check("replace_d_ready", D_ready, 8'h08);
    expect_beat(8'h5A, 3'd3);
    step();
    D_valid = 8'h00;
    @(negedge clk);
    check("replace_no_bubble_valid", Y_valid, 1);
    check("replace_no_bubble_y", Y, 8'h5A);
    step();

    // Reset while a stalled beat sits in Y.
    set_ch(2, 8'hA2);
    set_ch(3, 8'hA3);
    mode    = 1'b1;
    D_valid = 8'h10;
    expect_beat(8'hA4, 3'd4);
    step();
    Y_ready = 1'b0;
    D_valid = 8'hFF;
    rst     = 1'b1;
    @(negedge clk);
    check("midrst_d_ready", D_ready, 0);
    step();
    void'(exp_q.pop_back());  // that beat is discarded by the reset
    rst = 1'b0;
    @(negedge clk);
    check("midrst_y_valid", Y_valid, 0);
    check("midrst_y", Y, 0);
    Y_ready = 1'b1;
    expect_beat(8'hA0, 3'd0);
    step();
    D_valid = 8'h00;
    repeat (2) step();

`ifdef STREAM_MUX_PARITY_EN
    // Parity: 07 -> 1, 03 -> 0, held under stall.
    mode = 1'b0;
    S    = 3'd1;
    set_ch(1, 8'h07);
    D_valid = 8'h02;
    expect_beat(8'h07, 3'd1);
    step();
    set_ch(1, 8'h03);
    expect_beat(8'h03, 3'd1);
    step();
    Y_ready = 1'b0;
    D_valid = 8'h00;
    repeat (2) begin
      @(negedge clk);
      check("par_stall", Y_par, 0);
      step();
    end
    Y_ready = 1'b1;
    repeat (2) step();
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
